elastic_alu_pipeline: RTL and testbench

//  Parametrised successor of the fixed add/sub datapath pipeline. Stage 1 computes op1 (+|-) op2.

---
 rtl/elastic_alu_pipeline_if.sv | 29 ++
 rtl/elastic_alu_pipeline.sv | 100 ++++++++++
 tb/tb_elastic_alu_pipeline.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/elastic_alu_pipeline_if.sv
// Handshake bundle for elastic_alu_pipeline: operand/mode input side, result output side,
// flush and occupancy. Signal suffixes are from the pipeline's point of view.
interface elastic_alu_pipeline_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned STAGES = 3
);
  localparam int unsigned CW = $clog2(STAGES + 1);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DWIDTH-1:0] op1_i;
  logic [DWIDTH-1:0] op2_i;
  logic [1:0]        mode_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DWIDTH-1:0] res_o;
  logic [CW-1:0]     count_o;

  modport master (
    output in_valid_i, op1_i, op2_i, mode_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, count_o
  );

  modport slave (
    input  in_valid_i, op1_i, op2_i, mode_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, count_o
  );
endinterface

// File: rtl/elastic_alu_pipeline.sv
// Elastic add/sub pipeline: stage 1 op1 +/- op2, stage 2 s1 -/+ op1, remaining stages delay.
// Per-stage valid bits with a combinational ready chain give full backpressure without a skid buffer.
module elastic_alu_pipeline #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned STAGES = 3
) (
  input logic                   clk,
  input logic                   rst,
  elastic_alu_pipeline_if.slave bus
);
  localparam int unsigned CW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DWIDTH-1:0] data_q [STAGES];
  logic [DWIDTH-1:0] data_d [STAGES];
  logic [DWIDTH-1:0] op1_q, op1_d;
  logic [1:0]        mode_q, mode_d;
  logic [STAGES-1:0] adv;
  logic              accept;
  logic [CW-1:0]     cnt;

  // adv[i]: stage i may load this cycle (empty, or everything downstream moves)
  always_comb begin : ready_chain
    logic chain;
    chain = bus.out_ready_i;
    adv   = '0;
    for (int unsigned i = STAGES; i > 0; i--) begin
      chain    = ~valid_q[i-1] | chain;
      adv[i-1] = chain;
    end
  end

  assign bus.in_ready_o = adv[0] & ~bus.flush_i;
  assign accept         = bus.in_valid_i & bus.in_ready_o;

  always_comb begin : next_state
    valid_d = valid_q;
    data_d  = data_q;
    op1_d   = op1_q;
    mode_d  = mode_q;

    if (adv[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        data_d[0] = bus.mode_i[0] ? bus.op1_i - bus.op2_i : bus.op1_i + bus.op2_i;
        op1_d     = bus.op1_i;
        mode_d    = bus.mode_i;
      end
    end

    if (adv[1]) begin
      valid_d[1] = valid_q[0];
      if (valid_q[0]) begin
        data_d[1] = mode_q[1] ? data_q[0] + op1_q : data_q[0] - op1_q;
      end
    end

    for (int unsigned i = 2; i < STAGES; i++) begin
      if (adv[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end

    if (bus.flush_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      op1_q   <= '0;
      mode_q  <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      mode_q  <= mode_d;
      for (int unsigned i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin : occupancy
    cnt = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      cnt = cnt + CW'(valid_q[i]);
    end
  end

  assign bus.count_o     = cnt;
  assign bus.out_valid_o = valid_q[STAGES-1];
  assign bus.res_o       = data_q[STAGES-1];
endmodule

// File: tb/tb_elastic_alu_pipeline.sv
// Directed bench for elastic_alu_pipeline (DWIDTH=8, STAGES=3): reset, streaming, modulo
// arithmetic per mode, backpressure, flush and mid-flight reset against hand-computed results.
module tb_elastic_alu_pipeline;
  localparam int unsigned DW = 8;
  localparam int unsigned ST = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elastic_alu_pipeline_if #(.DWIDTH(DW), .STAGES(ST)) bus ();
  elastic_alu_pipeline #(.DWIDTH(DW), .STAGES(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sa [4];
  logic [7:0] sb [4];
  logic [7:0] se [4];
  logic [1:0] sm [4];
  int         cnt_exp [8] = '{1, 2, 3, 3, 2, 1, 0, 0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    bus.in_valid_i = 1'b1;
    bus.op1_i      = a;
    bus.op2_i      = b;
    bus.mode_i     = m;
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
  endtask

  // Four back-to-back transactions with the consumer always ready; results expected on edges 3..6.
  task automatic stream4(input string tag);
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        drive(sa[k], sb[k], sm[k]);
        #1 check_eq({tag, "_in_ready"}, 32'(bus.in_ready_o), 1);
      end else begin
        idle();
      end
      tick();
      check_eq({tag, "_out_valid"}, 32'(bus.out_valid_o), (k >= 2 && k <= 5) ? 1 : 0);
      check_eq({tag, "_count"}, 32'(bus.count_o), 32'(cnt_exp[k]));
      if (k >= 2 && k <= 5) begin
        check_eq({tag, "_res"}, 32'(bus.res_o), 32'(se[k-2]));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    drive(8'd55, 8'd66, 2'b11);

    // Reset with input asserted
    for (int c = 0; c < 2; c++) begin
      tick();
      check_eq("rst_out_valid", 32'(bus.out_valid_o), 0);
      check_eq("rst_count", 32'(bus.count_o), 0);
      check_eq("rst_res", 32'(bus.res_o), 0);
    end
    rst = 1'b0;
    idle();
    #1 check_eq("rst_in_ready", 32'(bus.in_ready_o), 1);

    // Mode 00 stream: result equals op2
    sa = '{8'd5, 8'd10, 8'd7, 8'd0};
    sb = '{8'd3, 8'd4, 8'd7, 8'd1};
    sm = '{2'b00, 2'b00, 2'b00, 2'b00};
    se = '{8'd3, 8'd4, 8'd7, 8'd1};
    stream4("stream");

    // Wraparound with all four modes
    sa = '{8'd200, 8'd200, 8'd200, 8'd200};
    sb = '{8'd100, 8'd100, 8'd100, 8'd100};
    sm = '{2'b00, 2'b10, 2'b01, 2'b11};
    se = '{8'd100, 8'd244, 8'd156, 8'd44};
    stream4("modes");

    // Backpressure: fill, hold, then drain in order
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(8'(k + 1), 8'(k + 1), 2'b00);
      tick();
    end
    drive(8'd4, 8'd4, 2'b00);
    #1;
    check_eq("bp_count_full", 32'(bus.count_o), 3);
    check_eq("bp_in_ready_full", 32'(bus.in_ready_o), 0);
    check_eq("bp_out_valid", 32'(bus.out_valid_o), 1);
    check_eq("bp_res_first", 32'(bus.res_o), 1);
    tick();
    tick();
    check_eq("bp_res_hold", 32'(bus.res_o), 1);
    check_eq("bp_valid_hold", 32'(bus.out_valid_o), 1);
    check_eq("bp_count_hold", 32'(bus.count_o), 3);
    bus.out_ready_i = 1'b1;
    #1 check_eq("bp_in_ready_drain", 32'(bus.in_ready_o), 1);
    tick();
    idle();
    check_eq("bp_count_accept_drain", 32'(bus.count_o), 3);
    check_eq("bp_res2", 32'(bus.res_o), 2);
    tick();
    check_eq("bp_valid3", 32'(bus.out_valid_o), 1);
    check_eq("bp_res3", 32'(bus.res_o), 3);
    tick();
    check_eq("bp_valid4", 32'(bus.out_valid_o), 1);
    check_eq("bp_res4", 32'(bus.res_o), 4);
    tick();
    check_eq("bp_valid_empty", 32'(bus.out_valid_o), 0);
    check_eq("bp_count_empty", 32'(bus.count_o), 0);

    // Flush with two in flight and input offered in the flush cycle
    bus.out_ready_i = 1'b0;
    drive(8'd11, 8'd22, 2'b00);
    tick();
    drive(8'd33, 8'd44, 2'b00);
    tick();
    check_eq("fl_count_before", 32'(bus.count_o), 2);
    bus.flush_i = 1'b1;
    drive(8'd99, 8'd1, 2'b00);
    #1 check_eq("fl_in_ready", 32'(bus.in_ready_o), 0);
    tick();
    bus.flush_i = 1'b0;
    idle();
    check_eq("fl_count_after", 32'(bus.count_o), 0);
    check_eq("fl_valid_after", 32'(bus.out_valid_o), 0);
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("fl_no_output", 32'(bus.out_valid_o), 0);
    end
    drive(8'd9, 8'd6, 2'b00);
    #1 check_eq("fl_in_ready_resume", 32'(bus.in_ready_o), 1);
    tick();
    idle();
    tick();
    tick();
    check_eq("fl_resume_valid", 32'(bus.out_valid_o), 1);
    check_eq("fl_resume_res", 32'(bus.res_o), 6);
    tick();
    check_eq("fl_resume_done", 32'(bus.out_valid_o), 0);

    // Reset while full and stalled
    bus.out_ready_i = 1'b0;
    drive(8'd1, 8'd2, 2'b00);
    tick();
    drive(8'd3, 8'd4, 2'b00);
    tick();
    drive(8'd5, 8'd6, 2'b00);
    tick();
    idle();
    check_eq("mr_count_full", 32'(bus.count_o), 3);
    check_eq("mr_res_stalled", 32'(bus.res_o), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mr_out_valid", 32'(bus.out_valid_o), 0);
    check_eq("mr_count", 32'(bus.count_o), 0);
    check_eq("mr_res", 32'(bus.res_o), 0);
    bus.out_ready_i = 1'b1;
    drive(8'd20, 8'd30, 2'b00);
    #1 check_eq("mr_in_ready", 32'(bus.in_ready_o), 1);
    tick();
    idle();
    tick();
    tick();
    check_eq("mr_resume_valid", 32'(bus.out_valid_o), 1);
    check_eq("mr_resume_res", 32'(bus.res_o), 30);
    tick();
    check_eq("mr_resume_done", 32'(bus.out_valid_o), 0);
    check_eq("mr_resume_count", 32'(bus.count_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
